text_console: RTL

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/text_console_pkg.sv | 24 ++
 rtl/console_addr.sv | 25 ++
 rtl/text_console.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/text_console_pkg.sv
// Shared constants, control codes and FSM states for the text console.
package text_console_pkg;

  localparam int COLS       = 80;
  localparam int ROWS       = 60;
  localparam int VRAM_CELLS = COLS * ROWS;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    CLEAR
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/console_addr.sv
// Maps (scroll offset, logical row, column) to a linear VRAM cell index.
// Latency: combinational; no flow control.
module console_addr #(
  parameter int COLS = text_console_pkg::COLS,
  parameter int ROWS = text_console_pkg::ROWS
) (
  input  logic [5:0]  line_i,
  input  logic [5:0]  row_i,
  input  logic [6:0]  col_i,
  output logic [12:0] addr_o
);
  import text_console_pkg::*;

  logic [6:0] sum;
  logic [5:0] phys;

  always_comb begin
    sum = {1'b0, line_i} + {1'b0, row_i};
    // Both operands are < ROWS, so a single conditional subtract is a full modulo.
    if (sum >= 7'(ROWS)) sum = sum - 7'(ROWS);
    phys   = sum[5:0];
    addr_o = 13'(phys) * 13'(COLS) + 13'(col_i);
  end

endmodule

// File: rtl/text_console.sv
// Character stream to VRAM writer with cursor, scrolling ring buffer and clear-screen.
// Latency: 1 cycle, all outputs registered; backpressure: CH_READY low outside IDLE (INIT/CLEAR).
module text_console #(
  parameter int COLS = text_console_pkg::COLS,
  parameter int ROWS = text_console_pkg::ROWS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CH_VALID,
  input  logic [7:0]  CH_DATA,
  output logic        CH_READY,
  output logic [12:0] ADDR,
  output logic        WRITE,
  output logic [7:0]  WRDATA,
  output logic [5:0]  LINE,
  output logic [6:0]  CUR_X,
  output logic [5:0]  CUR_Y
);
  import text_console_pkg::*;

  localparam int CELLS = COLS * ROWS;

  state_e      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [12:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [7:0]  wrdata_q, wrdata_d;
  logic        ready_q, ready_d;
  logic [5:0]  line_q, line_d;
  logic [6:0]  curx_q, curx_d;
  logic [5:0]  cury_q, cury_d;
  logic [6:0]  col;
  logic [12:0] cell_addr;
  logic        newline;

  // During CLEAR the cursor sits on the bottom row, so only the column is swept.
  assign col = (state_q == CLEAR) ? cnt_q[6:0] : curx_q;

  console_addr #(.COLS(COLS), .ROWS(ROWS)) u_addr (
    .line_i (line_q),
    .row_i  (cury_q),
    .col_i  (col),
    .addr_o (cell_addr)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = 1'b0;
    wrdata_d = wrdata_q;
    line_d   = line_q;
    curx_d   = curx_q;
    cury_d   = cury_q;
    newline  = 1'b0;

    case (state_q)
      INIT: begin
        write_d  = 1'b1;
        addr_d   = cnt_q;
        wrdata_d = BLANK;
        if (cnt_q == 13'(CELLS - 1)) begin
          cnt_d   = 13'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      CLEAR: begin
        write_d  = 1'b1;
        addr_d   = cell_addr;
        wrdata_d = BLANK;
        if (cnt_q == 13'(COLS - 1)) begin
          cnt_d   = 13'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      IDLE: begin
        if (CH_VALID) begin
          if (is_printable(CH_DATA)) begin
            write_d  = 1'b1;
            addr_d   = cell_addr;
            wrdata_d = CH_DATA;
            if (curx_q == 7'(COLS - 1)) newline = 1'b1;
            else                        curx_d  = curx_q + 7'd1;
          end else begin
            case (CH_DATA)
              LF: newline = 1'b1;
              CR: curx_d  = 7'd0;
              BS: if (curx_q != 7'd0) curx_d = curx_q - 7'd1;
              FF: begin
                line_d  = 6'd0;
                curx_d  = 7'd0;
                cury_d  = 6'd0;
                cnt_d   = 13'd0;
                state_d = INIT;
              end
              default: ;
            endcase
          end

          if (newline) begin
            curx_d = 7'd0;
            if (cury_q != 6'(ROWS - 1)) begin
              cury_d = cury_q + 6'd1;
            end else begin
              // The oldest physical row becomes the new bottom row and is blanked.
              line_d  = (line_q == 6'(ROWS - 1)) ? 6'd0 : line_q + 6'd1;
              cnt_d   = 13'd0;
              state_d = CLEAR;
            end
          end
        end
      end

      default: state_d = INIT;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wrdata_q <= '0;
      ready_q  <= 1'b0;
      line_q   <= '0;
      curx_q   <= '0;
      cury_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wrdata_q <= wrdata_d;
      ready_q  <= ready_d;
      line_q   <= line_d;
      curx_q   <= curx_d;
      cury_q   <= cury_d;
    end
  end

  assign CH_READY = ready_q;
  assign ADDR     = addr_q;
  assign WRITE    = write_q;
  assign WRDATA   = wrdata_q;
  assign LINE     = line_q;
  assign CUR_X    = curx_q;
  assign CUR_Y    = cury_q;

endmodule
